me_ctu_scheduler: RTL and testbench
===================================

# me_ctu_scheduler

Per-CTU sequencer for the motion-estimation (ME) engine. It accepts a CTU start request and runs the CTU through four phases: reference-window preload, search, PE-pipeline drain, and motion-vector (MV) report. It pulses `begin_prepare` to the reference-memory controller and meters preload beats from the external fetch path. During search it steps column and row counters that drive the PE array. It hands the finished result downstream through a valid/ready handshake.

## Interface
Parameters:
- `PRE_CYCLES`, default 768: preload beats per CTU (8 bank groups × 96 lines).
- `NUM_COLS`, default 14: search columns per CTU (two groups of 7).
- `COL_CYCLES`, default 44: cycles per column (20 for CB12 plus 24 for CB34).
- `PIPE_LAT`, default 4: PE pipeline drain cycles.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ctu_start` in 1: start request, accepted only while `ctu_ready`=1.
- `ctu_abort` in 1: abandon the current CTU.
- `ctu_ready` out 1: scheduler is idle.
- `begin_prepare` out 1: one-cycle pulse to the reference-memory controller.
- `fill_valid` in 1: external reference beat present.
- `fill_ready` out 1: scheduler accepts preload beats.
- `pe_stall` in 1: PE array back-pressure.
- `pe_en` out 1: PE array computes this cycle.
- `col_start` out 1: first row of a column is issued this cycle.
- `col_idx` out 4: current search column.
- `row_idx` out 6: current row within the column.
- `cb34` out 1: 0 selects sub-blocks 1/2 (rows 0–19), 1 selects sub-blocks 3/4 (rows 20–43).
- `mv_valid` out 1: result available.
- `mv_ready` in 1: downstream accepts the result.
- `ctu_done` out 1: one-cycle pulse when a CTU completes.
- `ctu_count` out 8: number of completed CTUs, wraps modulo 256.

## Operation
- States: IDLE, PREP, SEARCH, DRAIN, REPORT. Outputs are Moore decodes of registers.
- IDLE:
  - `ctu_ready`=1.
  - `ctu_start`=1 moves to PREP, clears `prep_cnt`, `col_idx` and `row_idx`, and sets `begin_prepare`=1 for exactly the first PREP cycle.
- PREP:
  - `fill_ready`=1.
  - `prep_cnt` increments only on cycles with `fill_valid`=1.
  - The beat accepted with `prep_cnt`=`PRE_CYCLES`-1 moves to SEARCH.
  - `fill_valid`=0 holds the counter with no timeout.
- SEARCH:
  - `pe_en` = !`pe_stall`.
  - On non-stalled cycles, `row_idx` increments. At `COL_CYCLES`-1 it wraps to 0 and `col_idx` increments.
  - `col_start` = (`row_idx`==0) & !`pe_stall`.
  - `cb34` = (`row_idx` ≥ 20).
  - A non-stalled cycle at `col_idx`=`NUM_COLS`-1 and `row_idx`=`COL_CYCLES`-1 moves to DRAIN.
  - `pe_stall`=1 freezes all counters and forces `pe_en`=0.
- DRAIN: `pe_en`=0. After exactly `PIPE_LAT` cycles (independent of `pe_stall`), move to REPORT.
- REPORT:
  - `mv_valid`=1 and stays high until `mv_ready`=1.
  - On the handshake cycle: move to IDLE next cycle, `ctu_done`=1 that next cycle, `ctu_count`+1.
- `ctu_abort`:
  - In any non-IDLE state: next state is IDLE.
  - No `ctu_done`, `ctu_count` unchanged, counters cleared.
  - Abort wins over every other transition in the same cycle.
  - Abort in IDLE has no effect.
- `ctu_start` outside IDLE is ignored; it is not queued.
- `begin_prepare` and `ctu_done` never assert in the same cycle.

## Timing
- Reset:
  - State IDLE.
  - `ctu_ready`=1.
  - All other outputs 0, including `ctu_count`=0, `col_idx`=0, `row_idx`=0, `cb34`=0.
  - Reset asserted mid-CTU returns to these values on the next edge, with no `ctu_done` pulse.
- Cycle-level sequence, with `ctu_start` accepted at cycle t, `fill_valid` held 1, `pe_stall` held 0, `mv_ready` held 1, and default parameters:
  - t+1: PREP entered, `begin_prepare`=1.
  - t+1 … t+768: PREP.
  - t+769 … t+1384: SEARCH (616 cycles).
  - t+1385 … t+1388: DRAIN.
  - t+1389: REPORT, `mv_valid`=1.
  - t+1390: `ctu_done`=1 and `ctu_ready`=1.
- Back-to-back operation: a start accepted at t+1390 re-enters PREP at t+1391.
- Every stalled cycle extends SEARCH by exactly one cycle.
- Every cycle with `fill_valid`=0 extends PREP by exactly one cycle.

## Test plan
- Reset, then a single CTU with ideal handshakes:
  - `begin_prepare` is high only at t+1.
  - `col_start` fires 14 times at t+769+44k.
  - `cb34` rises at row 20 of each column.
  - `ctu_done` at t+1390, `ctu_count`=1.
- `fill_valid` toggling 1,0 throughout PREP → SEARCH entry at t+1536. `fill_ready` drops exactly at SEARCH entry.
- `pe_stall`=1 for 5 cycles at `col_idx`=3, `row_idx`=10 → counters frozen and `pe_en`=0 during the stall. DRAIN starts 5 cycles late.
- `mv_ready` held 0 for 10 cycles in REPORT → `mv_valid` held high for 11 cycles. `ctu_done` is one cycle after the handshake.
- `ctu_abort` during SEARCH at `col_idx`=7 → IDLE next cycle, no `ctu_done`, `ctu_count` unchanged. `ctu_start` and `ctu_abort` asserted together in IDLE → CTU starts.
- Synchronous `rst` during PREP → all outputs at reset values the next cycle. 256 completed CTUs → `ctu_count` wraps to 0.

Source files
------------

// File: rtl/me_ctu_scheduler.sv
// Per-CTU sequencer for the motion-estimation engine: reference preload,
// PE-array search sweep, pipeline drain and MV report handshake.
module me_ctu_scheduler #(
  parameter int PRE_CYCLES = 768,
  parameter int NUM_COLS   = 14,
  parameter int COL_CYCLES = 44,
  parameter int PIPE_LAT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctu_start,
  input  logic       ctu_abort,
  output logic       ctu_ready,
  output logic       begin_prepare,
  input  logic       fill_valid,
  output logic       fill_ready,
  input  logic       pe_stall,
  output logic       pe_en,
  output logic       col_start,
  output logic [3:0] col_idx,
  output logic [5:0] row_idx,
  output logic       cb34,
  output logic       mv_valid,
  input  logic       mv_ready,
  output logic       ctu_done,
  output logic [7:0] ctu_count
);

  localparam int PW = $clog2(PRE_CYCLES + 1);
  localparam int DW = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_SEARCH,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   prep_cnt;
  logic [DW-1:0]   drain_cnt;

  logic abort_hit, prep_last, row_last, search_adv, search_last, drain_last, handshake;

  assign abort_hit   = ctu_abort && (state != S_IDLE);
  assign prep_last   = (state == S_PREP) && fill_valid && (prep_cnt == PW'(PRE_CYCLES - 1));
  assign row_last    = (row_idx == 6'(COL_CYCLES - 1));
  assign search_adv  = (state == S_SEARCH) && !pe_stall;
  assign search_last = search_adv && row_last && (col_idx == 4'(NUM_COLS - 1));
  assign drain_last  = (state == S_DRAIN) && (drain_cnt == DW'(PIPE_LAT - 1));
  // Abort beats the report handshake, so an aborted CTU is never counted.
  assign handshake   = (state == S_REPORT) && mv_ready && !ctu_abort;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: state_nx gets a default before the case so no path leaves it unassigned and no latch is inferred.
    state_nx = state;
    if (abort_hit) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (ctu_start)   state_nx = S_PREP;
        S_PREP:   if (prep_last)   state_nx = S_SEARCH;
        S_SEARCH: if (search_last) state_nx = S_DRAIN;
        S_DRAIN:  if (drain_last)  state_nx = S_REPORT;
        S_REPORT: if (handshake)   state_nx = S_IDLE;
        default:                   state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all registers use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      prep_cnt      <= '0;
      drain_cnt     <= '0;
      col_idx       <= '0;
      row_idx       <= '0;
      begin_prepare <= 1'b0;
      ctu_done      <= 1'b0;
      ctu_count     <= '0;
    end else begin
      begin_prepare <= (state == S_IDLE) && ctu_start;
      ctu_done      <= handshake;
      if (handshake) ctu_count <= ctu_count + 8'd1;

      if (abort_hit || state == S_IDLE) begin
        prep_cnt  <= '0;
        drain_cnt <= '0;
        col_idx   <= '0;
        row_idx   <= '0;
      end else begin
        if (state == S_PREP && fill_valid) prep_cnt <= prep_cnt + PW'(1);
        if (search_adv) begin
          if (row_last) begin
            row_idx <= '0;
            col_idx <= search_last ? 4'd0 : col_idx + 4'd1;
          end else begin
            row_idx <= row_idx + 6'd1;
          end
        end
        if (state == S_DRAIN) drain_cnt <= drain_cnt + DW'(1);
        else                  drain_cnt <= '0;
      end
    end
  end

  assign ctu_ready  = (state == S_IDLE);
  assign fill_ready = (state == S_PREP);
  assign pe_en      = search_adv;
  assign col_start  = search_adv && (row_idx == 6'd0);
  assign cb34       = (row_idx >= 6'd20);
  assign mv_valid   = (state == S_REPORT);

endmodule

// File: tb/tb_me_ctu_scheduler.sv
// Directed bench for me_ctu_scheduler: cycle-accurate CTU timelines on a
// default-parameter instance plus a counter-wrap run on a shrunken instance.
module tb_me_ctu_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ctu_start, ctu_abort, fill_valid, pe_stall, mv_ready;
  logic       ctu_ready, begin_prepare, fill_ready, pe_en, col_start, cb34, mv_valid, ctu_done;
  logic [3:0] col_idx;
  logic [5:0] row_idx;
  logic [7:0] ctu_count;

  logic       s_start, s_ready, s_bp, s_fill_ready, s_pe_en, s_col_start, s_cb34, s_mv_valid, s_done;
  logic [3:0] s_col;
  logic [5:0] s_row;
  logic [7:0] s_count;

  me_ctu_scheduler u_dut (
    .clk(clk), .rst(rst), .ctu_start(ctu_start), .ctu_abort(ctu_abort),
    .ctu_ready(ctu_ready), .begin_prepare(begin_prepare),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .pe_stall(pe_stall), .pe_en(pe_en), .col_start(col_start),
    .col_idx(col_idx), .row_idx(row_idx), .cb34(cb34),
    .mv_valid(mv_valid), .mv_ready(mv_ready),
    .ctu_done(ctu_done), .ctu_count(ctu_count)
  );

  me_ctu_scheduler #(.PRE_CYCLES(2), .NUM_COLS(2), .COL_CYCLES(3), .PIPE_LAT(1)) u_dut_small (
    .clk(clk), .rst(rst), .ctu_start(s_start), .ctu_abort(1'b0),
    .ctu_ready(s_ready), .begin_prepare(s_bp),
    .fill_valid(1'b1), .fill_ready(s_fill_ready),
    .pe_stall(1'b0), .pe_en(s_pe_en), .col_start(s_col_start),
    .col_idx(s_col), .row_idx(s_row), .cb34(s_cb34),
    .mv_valid(s_mv_valid), .mv_ready(1'b1),
    .ctu_done(s_done), .ctu_count(s_count)
  );

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set here act on the following edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One CTU on the default instance. Cycle 0 is the start cycle; every later
  // cycle is compared against the timeline expected for the given disturbances.
  task automatic run_ctu(input bit toggle, input int stall_at, input int stall_len,
                         input int mv_hold, input string tag);
    int prep_end, search_start, drain_start, report_start, hs;
    int s, row, col, n_cs, n_mv;
    int bad_bp, bad_fill, bad_pe, bad_cs, bad_cb, bad_idx, bad_mv, bad_done, bad_rdy;
    bit search, stalled;
    prep_end     = toggle ? 1535 : 768;
    search_start = prep_end + 1;
    drain_start  = search_start + 616 + stall_len;
    report_start = drain_start + 4;
    hs           = report_start + mv_hold;
    s = 0; n_cs = 0; n_mv = 0;
    bad_bp = 0; bad_fill = 0; bad_pe = 0; bad_cs = 0; bad_cb = 0;
    bad_idx = 0; bad_mv = 0; bad_done = 0; bad_rdy = 0;
    ctu_start = 1'b1;
    #1;
    check({tag, "_ready_at_start"}, ctu_ready, 1);
    cyc();
    ctu_start = 1'b0;
    for (int n = 1; n <= hs + 1; n++) begin
      fill_valid = toggle ? n[0] : 1'b1;
      pe_stall   = (stall_len > 0) && (n >= stall_at) && (n < stall_at + stall_len);
      mv_ready   = (n >= hs);
      #1;
      search  = (n >= search_start) && (n < drain_start);
      stalled = search && pe_stall;
      row = s % 44;
      col = s / 44;
      if (begin_prepare !== (n == 1)) bad_bp++;
      if (fill_ready !== (n <= prep_end)) bad_fill++;
      if (pe_en !== (search && !stalled)) bad_pe++;
      if (col_start !== (search && !stalled && row == 0)) bad_cs++;
      if (cb34 !== (search && row >= 20)) bad_cb++;
      if (search && (col_idx !== col[3:0] || row_idx !== row[5:0])) bad_idx++;
      if (mv_valid !== (n >= report_start && n <= hs)) bad_mv++;
      if (ctu_done !== (n == hs + 1)) bad_done++;
      if (ctu_ready !== (n > hs)) bad_rdy++;
      if (col_start === 1'b1) n_cs++;
      if (mv_valid === 1'b1) n_mv++;
      if (search && !stalled) s++;
      cyc();
    end
    fill_valid = 1'b1;
    pe_stall   = 1'b0;
    mv_ready   = 1'b1;
    check({tag, "_begin_prepare"}, bad_bp, 0);
    check({tag, "_fill_ready"}, bad_fill, 0);
    check({tag, "_pe_en"}, bad_pe, 0);
    check({tag, "_col_start"}, bad_cs, 0);
    check({tag, "_cb34"}, bad_cb, 0);
    check({tag, "_col_row_idx"}, bad_idx, 0);
    check({tag, "_mv_valid"}, bad_mv, 0);
    check({tag, "_ctu_done"}, bad_done, 0);
    check({tag, "_ctu_ready"}, bad_rdy, 0);
    check({tag, "_col_start_count"}, n_cs, 14);
    check({tag, "_mv_valid_cycles"}, n_mv, mv_hold + 1);
    exp_count++;
    check({tag, "_ctu_count"}, ctu_count, exp_count);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; ctu_start = 1'b0; ctu_abort = 1'b0;
    fill_valid = 1'b1; pe_stall = 1'b0; mv_ready = 1'b1; s_start = 1'b0;
    repeat (3) cyc();
    #1;
    check("rst_ctu_ready", ctu_ready, 1);
    check("rst_begin_prepare", begin_prepare, 0);
    check("rst_fill_ready", fill_ready, 0);
    check("rst_pe_en", pe_en, 0);
    check("rst_col_start", col_start, 0);
    check("rst_col_idx", col_idx, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_cb34", cb34, 0);
    check("rst_mv_valid", mv_valid, 0);
    check("rst_ctu_done", ctu_done, 0);
    check("rst_ctu_count", ctu_count, 0);
    rst = 1'b0;
    cyc();

    run_ctu(1'b0, 0, 0, 0, "ideal");
    run_ctu(1'b1, 0, 0, 0, "fill_toggle");
    run_ctu(1'b0, 911, 5, 0, "stall");
    run_ctu(1'b0, 0, 0, 10, "mv_hold");

    // Abort mid-search at column 7: back to IDLE next cycle, nothing counted.
    ctu_start = 1'b1;
    cyc();
    ctu_start = 1'b0;
    for (int n = 1; n < 1080; n++) cyc();
    #1;
    check("abort_pre_col_idx", col_idx, 7);
    ctu_abort = 1'b1;
    cyc();
    ctu_abort = 1'b0;
    #1;
    check("abort_ctu_ready", ctu_ready, 1);
    check("abort_col_idx", col_idx, 0);
    check("abort_row_idx", row_idx, 0);
    check("abort_pe_en", pe_en, 0);
    begin
      int dn = 0;
      for (int i = 0; i < 6; i++) begin
        if (ctu_done === 1'b1) dn++;
        cyc();
        #1;
      end
      check("abort_no_done", dn, 0);
    end
    check("abort_ctu_count", ctu_count, exp_count);

    // Start and abort together while idle: the start wins.
    ctu_start = 1'b1;
    ctu_abort = 1'b1;
    cyc();
    ctu_start = 1'b0;
    ctu_abort = 1'b0;
    #1;
    check("start_abort_idle_bp", begin_prepare, 1);
    check("start_abort_idle_fill_ready", fill_ready, 1);
    ctu_abort = 1'b1;
    cyc();
    ctu_abort = 1'b0;
    #1;
    check("prep_abort_ready", ctu_ready, 1);
    check("prep_abort_fill_ready", fill_ready, 0);

    // Synchronous reset during PREP.
    ctu_start = 1'b1;
    cyc();
    ctu_start = 1'b0;
    repeat (100) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("prep_rst_ctu_ready", ctu_ready, 1);
    check("prep_rst_fill_ready", fill_ready, 0);
    check("prep_rst_begin_prepare", begin_prepare, 0);
    check("prep_rst_ctu_done", ctu_done, 0);
    check("prep_rst_ctu_count", ctu_count, 0);

    // Back-to-back CTUs on the small instance until the count wraps.
    dcount = 0;
    s_start = 1'b1;
    for (int i = 0; i < 4000 && dcount < 256; i++) begin
      cyc();
      #1;
      if (s_done === 1'b1) begin
        dcount++;
        if (dcount == 1)   check("wrap_first_count", s_count, 1);
        if (dcount == 255) check("wrap_count_255", s_count, 255);
        if (dcount == 256) check("wrap_count_0", s_count, 0);
      end
      if (s_done === 1'b1 && s_bp === 1'b1) check("wrap_bp_done_overlap", 1, 0);
    end
    s_start = 1'b0;
    check("wrap_done_pulses", dcount, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
